// File: rtl/fp32_iterative_divider.sv
// fp32_iterative_divider: multi-cycle IEEE-754 binary32 divider (lhs / rhs).
// Uses radix-2 restoring mantissa division followed by one round stage.
// Rounding is round-to-nearest-even. Every invalid or NaN case returns NAN_VALUE.
// Only one operation is in flight at a time. The scheduler talks to the block through
// a req/ready/done handshake, and flush kills a wrong-path operation.
// Optional feature macro: FP_DIV_EARLY_OUT_EN. When it is defined, a special case
// found at capture skips CALC and goes straight to ROUND.
module fp32_iterative_divider #(
  parameter int          ITER_PER_CYCLE = 1,
  parameter logic [31:0] NAN_VALUE      = 32'h7fc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int         ITERS    = 26 / ITER_PER_CYCLE;
  localparam logic [4:0] LAST_CNT = 5'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ROUND, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [9:0]  exp_q, exp_d;       // biased exponent, two's complement
  logic [25:0] rem_q, rem_d;       // partial remainder
  logic [23:0] div_q, div_d;       // normalized divisor mantissa
  logic [25:0] quo_q, quo_d;       // 24 mantissa bits + guard + round
  logic [4:0]  cnt_q, cnt_d;
  logic        nan_q, nan_d;
  logic        inf_q, inf_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;

  logic        accept;

  // Leading-zero count of a 24-bit mantissa. A zero input returns 24.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Capture path: unpack both operands, pre-normalize subnormals, classify specials
  logic [7:0]  ex_a, ex_b;
  logic [22:0] fr_a, fr_b;
  logic [23:0] ma_raw, mb_raw, ma_norm, mb_norm;
  logic [4:0]  lz_a, lz_b;
  logic [9:0]  ea_eff, eb_eff, exp_cap;
  logic        a_lt;
  logic [24:0] ma_adj;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        cap_nan, cap_inf, cap_zero;

  always_comb begin
    ex_a    = lhs[30:23];
    ex_b    = rhs[30:23];
    fr_a    = lhs[22:0];
    fr_b    = rhs[22:0];
    ma_raw  = {|ex_a, fr_a};
    mb_raw  = {|ex_b, fr_b};
    lz_a    = lzc24(ma_raw);
    lz_b    = lzc24(mb_raw);
    ma_norm = ma_raw << lz_a;
    mb_norm = mb_raw << lz_b;
    // A subnormal operand behaves as exponent 1. The normalizing shift is then
    // taken off that exponent.
    ea_eff  = ((ex_a == 8'd0) ? 10'd1 : {2'b00, ex_a}) - {5'b00000, lz_a};
    eb_eff  = ((ex_b == 8'd0) ? 10'd1 : {2'b00, ex_b}) - {5'b00000, lz_b};
    // Keep the quotient in [1,2) so that the first quotient bit is always the hidden bit
    a_lt    = ma_norm < mb_norm;
    ma_adj  = a_lt ? {ma_norm, 1'b0} : {1'b0, ma_norm};
    exp_cap = ea_eff - eb_eff + 10'd127 - {9'd0, a_lt};

    a_nan    = (&ex_a) && (|fr_a);
    b_nan    = (&ex_b) && (|fr_b);
    a_inf    = (&ex_a) && !(|fr_a);
    b_inf    = (&ex_b) && !(|fr_b);
    a_zero   = (ex_a == 8'd0) && !(|fr_a);
    b_zero   = (ex_b == 8'd0) && !(|fr_b);
    cap_nan  = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    cap_inf  = !cap_nan && (a_inf || b_zero);
    cap_zero = !cap_nan && !cap_inf && (a_zero || b_inf);
  end

`ifdef FP_DIV_EARLY_OUT_EN
  logic cap_special;
  assign cap_special = cap_nan || cap_inf || cap_zero;
`endif

  // State register and result register. Both of these hold architecturally visible values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // Datapath registers. They are loaded on accept and are read only while an op is in flight.
  // NOTE: these need no reset because the control FSM never consumes them before an accept writes them.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    rem_q  <= rem_d;
    div_q  <= div_d;
    quo_q  <= quo_d;
    cnt_q  <= cnt_d;
    nan_q  <= nan_d;
    inf_q  <= inf_d;
    zero_q <= zero_d;
  end

  // Next-state logic. Flush beats req, and reset beats both in the register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req && !flush) begin
`ifdef FP_DIV_EARLY_OUT_EN
          state_d = cap_special ? S_ROUND : S_CALC;
`else
          state_d = S_CALC;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC:  state_d = flush ? S_IDLE : ((cnt_q == LAST_CNT) ? S_ROUND : S_CALC);
      S_ROUND: state_d = flush ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    busy   = (state_q == S_CALC) || (state_q == S_ROUND);
    done   = (state_q == S_DONE);
    accept = ready && req && !flush;
  end

  assign result = result_q;

  // Operand capture and the restoring iteration, ITER_PER_CYCLE quotient bits per cycle
  logic [25:0] rem_n;
  logic [25:0] quo_n;
  logic        q_bit;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves one unassigned (no latches).
    sign_d = sign_q;
    exp_d  = exp_q;
    rem_d  = rem_q;
    div_d  = div_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    nan_d  = nan_q;
    inf_d  = inf_q;
    zero_d = zero_q;
    rem_n  = rem_q;
    quo_n  = quo_q;
    q_bit  = 1'b0;

    if (accept) begin
      sign_d = lhs[31] ^ rhs[31];
      exp_d  = exp_cap;
      rem_d  = {1'b0, ma_adj};
      div_d  = mb_norm;
      quo_d  = 26'd0;
      cnt_d  = 5'd0;
      nan_d  = cap_nan;
      inf_d  = cap_inf;
      zero_d = cap_zero;
    end else if (state_q == S_CALC) begin
      // NOTE: blocking assignments here chain one restoring step into the next within a single cycle.
      for (int i = 0; i < ITER_PER_CYCLE; i++) begin
        q_bit = (rem_n >= {2'b00, div_q});
        if (q_bit) rem_n = rem_n - {2'b00, div_q};
        quo_n = {quo_n[24:0], q_bit};
        rem_n = {rem_n[24:0], 1'b0};
      end
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = (cnt_q == LAST_CNT) ? 5'd0 : cnt_q + 5'd1;
    end
  end

  // Round stage: denormalize on underflow, apply RNE, detect overflow, and override special cases
  logic        uflow;
  logic [9:0]  sh_full;
  logic [4:0]  sh;
  logic [25:0] q_sh;
  logic        lost, sticky, round_up;
  logic [9:0]  e_r, e_f;
  logic [24:0] m_rnd;
  logic [32:0] packed_sum;
  logic [31:0] rnd_result;

  always_comb begin
    uflow      = exp_q[9] || (exp_q == 10'd0);
    sh_full    = 10'd1 - exp_q;
    sh         = uflow ? ((sh_full > 10'd26) ? 5'd26 : sh_full[4:0]) : 5'd0;
    q_sh       = quo_q >> sh;
    lost       = |(quo_q & ((26'd1 << sh) - 26'd1));
    sticky     = (rem_q != 26'd0) || lost;
    round_up   = q_sh[1] && (q_sh[2] || q_sh[0] || sticky);
    m_rnd      = {1'b0, q_sh[25:2]} + {24'd0, round_up};
    e_r        = uflow ? 10'd0 : exp_q;
    // Add the mantissa into (e-1). The hidden bit, or a rounding carry, then lifts the
    // exponent field. A carry out of a subnormal therefore turns it into the minimum normal.
    e_f        = (e_r == 10'd0) ? 10'd0 : e_r - 10'd1;
    packed_sum = {e_f, 23'd0} + {8'd0, m_rnd};

    if (nan_q) begin
      rnd_result = NAN_VALUE;
    end else if (inf_q || (packed_sum[32:23] >= 10'd255)) begin
      rnd_result = {sign_q, 8'hff, 23'd0};
    end else if (zero_q) begin
      rnd_result = {sign_q, 31'd0};
    end else begin
      rnd_result = {sign_q, packed_sum[30:0]};
    end

    result_d = result_q;
    if ((state_q == S_ROUND) && !flush) result_d = rnd_result;
  end

endmodule

// File: tb/tb_fp32_iterative_divider.sv
// Directed testbench for fp32_iterative_divider. Each expected value is hand-computed.
// Latency is counted as the number of falling edges from acceptance until done is seen.
module tb_fp32_iterative_divider;

  logic        clk = 1'b0;
  logic        rst, req, flush;
  logic [31:0] lhs, rhs;
  logic        ready, busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int LAT = 28;
`ifdef FP_DIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 2;
`else
  localparam int SPEC_LAT = 28;
`endif

  fp32_iterative_divider dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lhs    (lhs),
    .rhs    (rhs),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The caller must be sitting at a falling edge. The op is issued, and the task returns
  // at the falling edge of the done cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit chk_hs);
    int lat;
    bit hs_bad;
    lhs = a; rhs = b; req = 1'b1;
    hs_bad = 1'b0;
    lat = 1;
    @(negedge clk);
    req = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (ready !== 1'b0 || busy !== 1'b1) hs_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    if (chk_hs) check({tag, "_hs"}, {31'd0, hs_bad}, 32'd0);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; lhs = 32'd0; rhs = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready",  {31'd0, ready}, 32'd1);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_done",   {31'd0, done},  32'd0);
    check("rst_result", result,         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic op: 6/2 = 3. After done, the pulse must drop and the result must hold.
    run_op("basic", 32'h40C00000, 32'h40000000, 32'h40400000, LAT, 1'b1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("res_hold",   result,        32'h40400000);

    // Rounding cases
    run_op("third",     32'h3F800000, 32'h40400000, 32'h3EAAAAAB, LAT, 1'b0);
    @(negedge clk);
    run_op("neg_third", 32'hBF800000, 32'h40400000, 32'hBEAAAAAB, LAT, 1'b0);
    @(negedge clk);

    // Range cases: subnormal output, subnormal input, overflow, underflow to zero
    run_op("sub_out",   32'h00800000, 32'h40000000, 32'h00400000, LAT, 1'b0);
    @(negedge clk);
    run_op("sub_in",    32'h00000001, 32'h3F000000, 32'h00000002, LAT, 1'b0);
    @(negedge clk);
    run_op("ovf",       32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, LAT, 1'b0);
    @(negedge clk);
    run_op("uflow",     32'h00000001, 32'h40800000, 32'h00000000, LAT, 1'b0);
    @(negedge clk);
    run_op("sub_sub",   32'h00000003, 32'h00000001, 32'h40400000, LAT, 1'b0);
    @(negedge clk);

    // Special cases
    run_op("x_div_0",   32'h3F800000, 32'h00000000, 32'h7F800000, SPEC_LAT, 1'b0);
    @(negedge clk);
    run_op("0_div_0",   32'h00000000, 32'h00000000, 32'h7FC00000, SPEC_LAT, 1'b0);
    @(negedge clk);
    run_op("inf_inf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, SPEC_LAT, 1'b0);
    @(negedge clk);
    run_op("x_div_inf", 32'h3F800000, 32'hFF800000, 32'h80000000, SPEC_LAT, 1'b0);
    @(negedge clk);
    run_op("nan_in",    32'h7FC12345, 32'h3F800000, 32'h7FC00000, SPEC_LAT, 1'b0);

    // Back-to-back: a request made in the DONE cycle is accepted straight away
    check("b2b_ready", {31'd0, ready}, 32'd1);
    run_op("b2b",       32'h40C00000, 32'h40000000, 32'h40400000, LAT, 1'b1);
    @(negedge clk);

    // Flush at cycle 10 of an op. There must be no done, ready must return, and the result must stay unchanged.
    lhs = 32'h3F800000; rhs = 32'h40400000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_busy",  {31'd0, busy},  32'd0);
    count_done("flush_no_done", 40);
    check("flush_res",   result,         32'h40400000);

    // A flush in the same cycle as a req while IDLE blocks acceptance
    lhs = 32'h40C00000; rhs = 32'h40000000; req = 1'b1; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    check("flush_blocks_req", {31'd0, busy}, 32'd0);

    run_op("after_flush", 32'h41200000, 32'h40A00000, 32'h40000000, LAT, 1'b0);
    @(negedge clk);

    // Reset at cycle 15 of an op
    lhs = 32'h40C00000; rhs = 32'h40000000; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",  {31'd0, ready}, 32'd1);
    check("mid_rst_busy",   {31'd0, busy},  32'd0);
    check("mid_rst_done",   {31'd0, done},  32'd0);
    check("mid_rst_result", result,         32'd0);
    count_done("mid_rst_no_done", 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
